pwm_burst_scheduler: RTL and testbench

// - Sequences burst launches onto the _NUM_CHANNELS high-speed PWM channels from decoded UART commands.
// - Sits between the UART register mapper (command source) and the PWM channel bank.
// - Queues commands in order, launches each one only when its target channel is idle, and confirms the launch.
// - Enforces a guard gap between consecutive launches and reports drop and timeout errors.

---
 rtl/pwm_burst_scheduler_pkg.sv | 10 +
 rtl/pwm_burst_scheduler_if.sv | 31 +++
 rtl/pwm_burst_scheduler_cmd_fifo.sv | 42 ++++
 rtl/pwm_burst_scheduler.sv | 105 ++++++++++
 tb/tb_pwm_burst_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_burst_scheduler_pkg.sv
// pwm_burst_scheduler_pkg: shared FSM encoding, queue entry layout and widths for the burst scheduler
package pwm_burst_scheduler_pkg;
    localparam int CH_W = 8;
    localparam int ENTRY_W = 16;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_GAP} state_t;
    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [7:0]      num;
    } cmd_t;
endpackage

// File: rtl/pwm_burst_scheduler_if.sv
// pwm_burst_scheduler_if: command, PWM bank and status signals of the burst scheduler
interface pwm_burst_scheduler_if
    import pwm_burst_scheduler_pkg::*;
#(
    parameter int _NUM_CHANNELS = 3,
    parameter int FIFO_DEPTH = 4
);
    logic                          cmd_valid;
    logic [CH_W-1:0]               cmd_ch;
    logic [7:0]                    cmd_pulse_num;
    logic                          cmd_ready;
    logic                          abort;
    logic [_NUM_CHANNELS-1:0]      pwm_busy;
    logic [_NUM_CHANNELS-1:0]      pwm_start;
    logic [7:0]                    pwm_pulse_num;
    logic                          sched_busy;
    logic [$clog2(FIFO_DEPTH):0]   queue_level;
    logic                          err_overflow;
    logic                          err_bad_ch;
    logic                          err_timeout;
    modport master (
        output cmd_valid, cmd_ch, cmd_pulse_num, abort, pwm_busy,
        input  cmd_ready, pwm_start, pwm_pulse_num, sched_busy, queue_level,
               err_overflow, err_bad_ch, err_timeout
    );
    modport slave (
        input  cmd_valid, cmd_ch, cmd_pulse_num, abort, pwm_busy,
        output cmd_ready, pwm_start, pwm_pulse_num, sched_busy, queue_level,
               err_overflow, err_bad_ch, err_timeout
    );
endinterface

// File: rtl/pwm_burst_scheduler_cmd_fifo.sv
// pwm_burst_scheduler_cmd_fifo: show-ahead command queue with flush and occupancy count
module pwm_burst_scheduler_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    ptr_t wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];
    // pointer update; the extra MSB tells full from empty when the indices coincide
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end
    // storage is write-only on push and needs no reset, the pointers define validity
    always_ff @(posedge clk_50M) begin
        if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pwm_burst_scheduler.sv
// pwm_burst_scheduler: queues channel burst commands and launches them in order onto idle PWM channels
module pwm_burst_scheduler
    import pwm_burst_scheduler_pkg::*;
#(
    parameter int _NUM_CHANNELS = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 50,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk_50M,
    input  logic                   rst,
    pwm_burst_scheduler_if.slave   bus
);
    localparam logic [CH_W-1:0] CH_LIM   = CH_W'(_NUM_CHANNELS);
    localparam logic [16:0]     GAP_LAST = 17'(GAP_CYCLES);
    localparam logic [7:0]      ACK_LIM  = 8'(ACK_TIMEOUT);
    state_t                       state;
    cmd_t                         head;
    logic                         full, empty, push, pop, ch_ok;
    logic                         head_busy, cur_busy, gap_done, ack_done;
    logic [_NUM_CHANNELS-1:0]     head_oh, cur_oh;
    logic [7:0]                   ack_cnt;
    logic [15:0]                  gap_cnt;
    logic [$clog2(FIFO_DEPTH):0]  level;
    pwm_burst_scheduler_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk_50M (clk_50M),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.abort),
        .din     ({bus.cmd_ch, bus.cmd_pulse_num}),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );
    // command acceptance, head-of-queue channel lookup and terminal-count decode
    always_comb begin
        ch_ok     = bus.cmd_ch < CH_LIM;
        push      = bus.cmd_valid && !full && ch_ok && !bus.abort;
        head_oh   = _NUM_CHANNELS'(1) << head.ch;
        head_busy = |(bus.pwm_busy & head_oh);
        cur_busy  = |(bus.pwm_busy & cur_oh);
        pop       = (state == S_IDLE) && !empty && !head_busy && !bus.abort;
        gap_done  = (17'(gap_cnt) + 17'd1) >= GAP_LAST;
        ack_done  = (ack_cnt + 8'd1) == ACK_LIM;
    end
    assign bus.cmd_ready   = !full;
    assign bus.queue_level = level;
    assign bus.sched_busy  = (state != S_IDLE) || !empty;
    // launch FSM with registered strobes; abort returns to IDLE but never cuts a start pulse short
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cur_oh            <= '0;
            ack_cnt           <= '0;
            gap_cnt           <= '0;
            bus.pwm_start     <= '0;
            bus.pwm_pulse_num <= '0;
            bus.err_overflow  <= 1'b0;
            bus.err_bad_ch    <= 1'b0;
            bus.err_timeout   <= 1'b0;
        end else begin
            bus.pwm_start     <= '0;
            bus.pwm_pulse_num <= '0;
            bus.err_timeout   <= 1'b0;
            bus.err_bad_ch    <= bus.cmd_valid && !bus.abort && !ch_ok;
            bus.err_overflow  <= bus.cmd_valid && !bus.abort && ch_ok && full;
            if (bus.abort) begin
                state   <= S_IDLE;
                ack_cnt <= '0;
                gap_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pop && head.num != 8'd0) begin
                            state             <= S_ISSUE;
                            cur_oh            <= head_oh;
                            bus.pwm_start     <= head_oh;
                            bus.pwm_pulse_num <= head.num;
                        end
                    end
                    S_ISSUE: begin
                        state   <= S_WAIT_ACK;
                        ack_cnt <= '0;
                    end
                    S_WAIT_ACK: begin
                        if (cur_busy || ack_done) begin
                            state           <= S_GAP;
                            gap_cnt         <= '0;
                            ack_cnt         <= '0;
                            bus.err_timeout <= !cur_busy;
                        end else begin
                            ack_cnt <= ack_cnt + 8'd1;
                        end
                    end
                    S_GAP: begin
                        state   <= gap_done ? S_IDLE : S_GAP;
                        gap_cnt <= gap_done ? '0 : gap_cnt + 16'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_burst_scheduler.sv
// tb_pwm_burst_scheduler: directed vector table plus hand-written launch, timeout, abort and reset sequences
module tb_pwm_burst_scheduler;
    logic clk_50M = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    pwm_burst_scheduler_if #(._NUM_CHANNELS(3), .FIFO_DEPTH(4)) bus ();
    pwm_burst_scheduler #(
        ._NUM_CHANNELS(3), .FIFO_DEPTH(4), .GAP_CYCLES(50), .ACK_TIMEOUT(255)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .bus     (bus)
    );
    // 50 MHz clock
    always #10 clk_50M = ~clk_50M;
    // hard stop in case a sequence loses sync with the design
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    typedef struct {
        logic       v;
        logic [7:0] ch;
        logic [7:0] num;
        logic       ab;
        logic [2:0] busy;
        logic       rdy;
        logic [2:0] lvl;
        logic       bad;
        logic       ovf;
        logic [2:0] st;
        logic       sb;
    } vec_t;
    vec_t vecs [16];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
        end
    endtask
    task automatic push(input logic [7:0] ch, input logic [7:0] num);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch = ch;
        bus.cmd_pulse_num = num;
        step(1);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic wait_start(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step(1);
            seen = bus.pwm_start != 3'b000;
        end
        chk("start_seen", 32'(seen), 32'd1);
    endtask
    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_start"}, 32'(bus.pwm_start), 32'd0);
        chk({tag, "_pnum"}, 32'(bus.pwm_pulse_num), 32'd0);
        chk({tag, "_sbusy"}, 32'(bus.sched_busy), 32'd0);
        chk({tag, "_level"}, 32'(bus.queue_level), 32'd0);
        chk({tag, "_errs"}, 32'({bus.err_overflow, bus.err_bad_ch, bus.err_timeout}), 32'd0);
    endtask
    initial begin
        int cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch = 8'd0;
        bus.cmd_pulse_num = 8'd0;
        bus.abort = 1'b0;
        bus.pwm_busy = 3'b000;
        //             v   ch      num    ab    busy    rdy  lvl   bad  ovf  st      sb
        vecs[0]  = '{1'b1, 8'd2,   8'd1, 1'b0, 3'b100, 1'b1, 3'd1, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[1]  = '{1'b1, 8'd2,   8'd1, 1'b0, 3'b100, 1'b1, 3'd2, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[2]  = '{1'b1, 8'd2,   8'd1, 1'b0, 3'b100, 1'b1, 3'd3, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[3]  = '{1'b1, 8'd2,   8'd1, 1'b0, 3'b100, 1'b0, 3'd4, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[4]  = '{1'b1, 8'd2,   8'd1, 1'b0, 3'b100, 1'b0, 3'd4, 1'b0, 1'b1, 3'b000, 1'b1};
        vecs[5]  = '{1'b1, 8'd2,   8'd1, 1'b0, 3'b100, 1'b0, 3'd4, 1'b0, 1'b1, 3'b000, 1'b1};
        vecs[6]  = '{1'b0, 8'd0,   8'd0, 1'b0, 3'b100, 1'b0, 3'd4, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[7]  = '{1'b1, 8'd3,   8'd1, 1'b0, 3'b100, 1'b0, 3'd4, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[8]  = '{1'b1, 8'd0,   8'd1, 1'b1, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[9]  = '{1'b0, 8'd0,   8'd0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[10] = '{1'b1, 8'd5,   8'd4, 1'b0, 3'b100, 1'b1, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0};
        vecs[11] = '{1'b1, 8'd255, 8'd4, 1'b0, 3'b100, 1'b1, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0};
        vecs[12] = '{1'b0, 8'd0,   8'd0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[13] = '{1'b1, 8'd0,   8'd0, 1'b0, 3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[14] = '{1'b0, 8'd0,   8'd0, 1'b0, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[15] = '{1'b0, 8'd0,   8'd0, 1'b0, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0};
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M);
        chk_reset_values("reset");
        rst = 1'b0;
        step(1);
        chk_reset_values("post_reset");
        // overflow, bad channel, abort with a pending command, zero-length no-op
        for (int i = 0; i < 16; i++) begin
            bus.cmd_valid = vecs[i].v;
            bus.cmd_ch = vecs[i].ch;
            bus.cmd_pulse_num = vecs[i].num;
            bus.abort = vecs[i].ab;
            bus.pwm_busy = vecs[i].busy;
            step(1);
            chk($sformatf("vec%0d_ready", i), 32'(bus.cmd_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_level", i), 32'(bus.queue_level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_bad_ch", i), 32'(bus.err_bad_ch), 32'(vecs[i].bad));
            chk($sformatf("vec%0d_overflow", i), 32'(bus.err_overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_start", i), 32'(bus.pwm_start), 32'(vecs[i].st));
            chk($sformatf("vec%0d_sbusy", i), 32'(bus.sched_busy), 32'(vecs[i].sb));
        end
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        bus.pwm_busy = 3'b000;
        // single launch: start two cycles after accept, 50 gap cycles after the ack
        push(8'd1, 8'd5);
        chk("single_t1_start", 32'(bus.pwm_start), 32'd0);
        chk("single_t1_level", 32'(bus.queue_level), 32'd1);
        step(1);
        chk("single_start", 32'(bus.pwm_start), 32'b010);
        chk("single_pnum", 32'(bus.pwm_pulse_num), 32'd5);
        chk("single_level", 32'(bus.queue_level), 32'd0);
        step(1);
        chk("single_start_off", 32'(bus.pwm_start), 32'd0);
        chk("single_pnum_off", 32'(bus.pwm_pulse_num), 32'd0);
        step(2);
        bus.pwm_busy = 3'b010;
        chk("single_wait_sbusy", 32'(bus.sched_busy), 32'd1);
        cnt = 0;
        for (int i = 0; i < 200 && bus.sched_busy; i++) begin
            step(1);
            cnt++;
        end
        chk("single_gap_len", 32'(cnt), 32'd51);
        chk("single_no_timeout", 32'(bus.err_timeout), 32'd0);
        bus.pwm_busy = 3'b000;
        // in-order launch behind a busy channel
        bus.pwm_busy = 3'b001;
        push(8'd0, 8'd2);
        push(8'd0, 8'd3);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus.pwm_start != 3'b000) cnt++;
        end
        chk("blocked_no_start", 32'(cnt), 32'd0);
        chk("blocked_level", 32'(bus.queue_level), 32'd2);
        bus.pwm_busy = 3'b000;
        wait_start(10);
        chk("order_first_start", 32'(bus.pwm_start), 32'b001);
        chk("order_first_pnum", 32'(bus.pwm_pulse_num), 32'd2);
        bus.pwm_busy = 3'b001;
        step(5);
        bus.pwm_busy = 3'b000;
        wait_start(100);
        chk("order_second_start", 32'(bus.pwm_start), 32'b001);
        chk("order_second_pnum", 32'(bus.pwm_pulse_num), 32'd3);
        bus.pwm_busy = 3'b001;
        step(3);
        bus.pwm_busy = 3'b000;
        for (int i = 0; i < 100 && bus.sched_busy; i++) step(1);
        chk("order_idle", 32'(bus.sched_busy), 32'd0);
        // ack timeout, then the queued command still launches
        push(8'd0, 8'd1);
        wait_start(5);
        push(8'd0, 8'd7);
        cnt = 0;
        for (int i = 0; i < 400 && !bus.err_timeout; i++) begin
            step(1);
            cnt++;
        end
        chk("timeout_latency", 32'(cnt), 32'd255);
        chk("timeout_pulse", 32'(bus.err_timeout), 32'd1);
        step(1);
        chk("timeout_one_cycle", 32'(bus.err_timeout), 32'd0);
        wait_start(100);
        chk("timeout_next_pnum", 32'(bus.pwm_pulse_num), 32'd7);
        // abort while the start strobe is on: strobe ends normally, FSM returns to IDLE
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        chk("abort_issue_sbusy", 32'(bus.sched_busy), 32'd0);
        chk("abort_issue_start", 32'(bus.pwm_start), 32'd0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (bus.err_timeout || bus.pwm_start != 3'b000) cnt++;
        end
        chk("abort_issue_quiet", 32'(cnt), 32'd0);
        // abort flushes a queue of three
        bus.pwm_busy = 3'b100;
        push(8'd2, 8'd1);
        push(8'd2, 8'd1);
        push(8'd2, 8'd1);
        chk("abort_q_level", 32'(bus.queue_level), 32'd3);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        chk("abort_q_flushed", 32'(bus.queue_level), 32'd0);
        chk("abort_q_sbusy", 32'(bus.sched_busy), 32'd0);
        chk("abort_q_ready", 32'(bus.cmd_ready), 32'd1);
        bus.pwm_busy = 3'b000;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.pwm_start != 3'b000 || bus.err_overflow || bus.err_bad_ch) cnt++;
        end
        chk("abort_q_quiet", 32'(cnt), 32'd0);
        // asynchronous reset during GAP
        push(8'd1, 8'd4);
        wait_start(5);
        bus.pwm_busy = 3'b010;
        step(5);
        chk("gap_sbusy", 32'(bus.sched_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        step(2);
        rst = 1'b0;
        bus.pwm_busy = 3'b000;
        step(3);
        chk_reset_values("after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
